// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian push-button request controller.
//
// Each of four raw buttons is synchronised (2 flops) and debounced. A debounced
// rising edge latches a pending request for that crossing. A two-state FSM offers
// one pending lane downstream at a time. It picks lanes round-robin and holds the
// offer until req_ack.
//
// Optional feature: define PED_WAIT_CNT_EN to add per-lane 8-bit saturating wait
// counters that drive wait_alarm. Without it, wait_alarm is tied to 0.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing synchronised cycles to flip state (1..15)
//   MAX_WAIT         wait-cycle threshold for wait_alarm (1..255)
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   btn[3:0]     raw asynchronous buttons, bit i = crossing P(i+1)
//   req_ack      downstream accepts the offered request
//   ped_pending  latched outstanding requests
//   req_valid    a request is offered downstream
//   req_lane     crossing index of the offered request
//   wait_alarm   lane request has waited >= MAX_WAIT cycles
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT        = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       req_ack,
  output logic [3:0] ped_pending,
  output logic       req_valid,
  output logic [1:0] req_lane,
  output logic [3:0] wait_alarm
);

  localparam logic [3:0] DebLimit = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StIdle, StOffer} state_e;

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_q, deb_d, deb_prev_q;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0]      press;
  logic [3:0]      pending_q, pending_d, clr;
  state_e          state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      pick;
  logic            found;

  // Debounce: count cycles where the synchronised value disagrees with the
  // debounced state; flip on the DEBOUNCE_CYCLES-th one, clear on agreement.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebLimit) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // One-cycle pulse in the cycle after the debounced state rises.
  assign press = deb_q & ~deb_prev_q;

  // Round-robin search upward from rr_q.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int off = 0; off < 4; off++) begin
      if (!found && pending_q[rr_q + 2'(off)]) begin
        pick  = rr_q + 2'(off);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    rr_d    = rr_q;
    clr     = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          lane_d  = pick;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (req_ack) begin
          clr[lane_q] = 1'b1;
          rr_d        = lane_q + 2'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A press landing in the ack cycle re-sets the bit after the clear.
  assign pending_d = (pending_q & ~clr) | press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pending_q  <= '0;
      state_q    <= StIdle;
      lane_q     <= '0;
      rr_q       <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      lane_q     <= lane_d;
      rr_q       <= rr_d;
    end
  end

  assign ped_pending = pending_q;
  assign req_valid   = (state_q == StOffer);
  assign req_lane    = lane_q;

`ifdef PED_WAIT_CNT_EN
  logic [3:0][7:0] wait_q, wait_d;

  always_comb begin
    wait_d     = '0;
    wait_alarm = '0;
    for (int i = 0; i < 4; i++) begin
      if (pending_q[i]) begin
        wait_d[i] = (wait_q[i] == 8'hff) ? 8'hff : wait_q[i] + 8'd1;
      end
      wait_alarm[i] = (wait_q[i] >= 8'(MAX_WAIT));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign wait_alarm = '0;
`endif

endmodule
